// File: rtl/gate_truth_checker.sv
// Self-test engine for a 2-input gate: walks {A,B} = 00..11, waits SETTLE cycles,
// samples Y and scores it against the EXPECTED truth table.
module gate_truth_checker #(
    parameter logic [3:0] EXPECTED = 4'b1110,
    parameter int         SETTLE   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] captured,
    output logic [3:0] err_mask,
    output logic [2:0] err_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_C   = 4'(SETTLE);
    localparam logic       SKIP_APPLY = (SETTLE == 0);

    state_t     state_r;
    logic [1:0] idx_r;
    logic [3:0] cnt_r;
    logic [3:0] cnt_inc_s;
    logic [1:0] idx_inc_s;
    logic       err_bit_s;
    logic [3:0] cap_next_s;
    logic [3:0] mask_next_s;

    // Counting set bits of the mask keeps err_count bounded at 4 by construction.
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // Next-value results for the vector currently being sampled.
    always_comb begin
        cnt_inc_s          = cnt_r + 4'd1;
        idx_inc_s          = idx_r + 2'd1;
        err_bit_s          = y_in ^ EXPECTED[idx_r];
        cap_next_s         = captured;
        cap_next_s[idx_r]  = y_in;
        mask_next_s        = err_mask;
        mask_next_s[idx_r] = err_bit_s;
    end

    // Run sequencer with registered outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            idx_r     <= 2'd0;
            cnt_r     <= 4'd0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            captured  <= 4'd0;
            err_mask  <= 4'd0;
            err_count <= 3'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    a_out <= 1'b0;
                    b_out <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        idx_r     <= 2'd0;
                        cnt_r     <= 4'd0;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        captured  <= 4'd0;
                        err_mask  <= 4'd0;
                        err_count <= 3'd0;
                        state_r   <= SKIP_APPLY ? SAMPLE : APPLY;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                APPLY: begin
                    cnt_r <= cnt_inc_s;
                    if (cnt_inc_s == SETTLE_C) begin
                        state_r <= SAMPLE;
                    end else begin
                        state_r <= APPLY;
                    end
                end
                SAMPLE: begin
                    captured  <= cap_next_s;
                    err_mask  <= mask_next_s;
                    err_count <= popcount4(mask_next_s);
                    cnt_r     <= 4'd0;
                    if (idx_r == 2'd3) begin
                        a_out   <= 1'b0;
                        b_out   <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (mask_next_s == 4'd0);
                        state_r <= FINISH;
                    end else begin
                        idx_r   <= idx_inc_s;
                        a_out   <= idx_inc_s[1];
                        b_out   <= idx_inc_s[0];
                        state_r <= SKIP_APPLY ? SAMPLE : APPLY;
                    end
                end
                FINISH: begin
                    // start is deliberately ignored here; earliest restart is next cycle.
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    a_out   <= 1'b0;
                    b_out   <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: default (SETTLE=2) and SETTLE=0 instances,
// behavioural gate models (OR, AND, stuck-at-1) driving y_in.
module tb_gate_truth_checker;

    logic clk = 1'b0;
    logic rst;
    logic start0, start1;
    logic a0, b0, y0, busy0, done0, pass0;
    logic a1, b1, y1, busy1, done1, pass1;
    logic [3:0] cap0, mask0, cap1, mask1;
    logic [2:0] cnt0, cnt1;
    int mode;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // 0 = OR, 1 = AND, 2 = stuck at 1
    function automatic logic gate_model(input int m, input logic a, input logic b);
        case (m)
            0:       gate_model = a | b;
            1:       gate_model = a & b;
            default: gate_model = 1'b1;
        endcase
    endfunction

    assign y0 = gate_model(mode, a0, b0);
    assign y1 = gate_model(mode, a1, b1);

    gate_truth_checker dut0 (
        .clk(clk), .rst(rst), .start(start0), .a_out(a0), .b_out(b0), .y_in(y0),
        .busy(busy0), .done(done0), .pass(pass0), .captured(cap0),
        .err_mask(mask0), .err_count(cnt0)
    );

    gate_truth_checker #(.EXPECTED(4'b1110), .SETTLE(0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_out(a1), .b_out(b1), .y_in(y1),
        .busy(busy1), .done(done1), .pass(pass1), .captured(cap1),
        .err_mask(mask1), .err_count(cnt1)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observation of one instance: {a,b,busy,done,pass} and the result fields.
    function automatic logic [4:0] ctl_of(input int sel);
        ctl_of = (sel == 0) ? {a0, b0, busy0, done0, pass0} : {a1, b1, busy1, done1, pass1};
    endfunction

    function automatic logic [10:0] res_of(input int sel);
        res_of = (sel == 0) ? {cap0, mask0, cnt0} : {cap1, mask1, cnt1};
    endfunction

    task automatic check_results(input int sel, input string tag, input logic [3:0] e_cap,
                                 input logic [3:0] e_mask, input logic [2:0] e_cnt,
                                 input logic e_pass);
        logic [10:0] r;
        logic [4:0]  c;
        r = res_of(sel);
        c = ctl_of(sel);
        chk({tag, " captured"}, {4'd0, r[10:7]}, {4'd0, e_cap});
        chk({tag, " err_mask"}, {4'd0, r[6:3]}, {4'd0, e_mask});
        chk({tag, " err_count"}, {5'd0, r[2:0]}, {5'd0, e_cnt});
        chk({tag, " pass"}, {7'd0, c[0]}, {7'd0, e_pass});
    endtask

    // One run from a start pulse at cycle 0, checking outputs every cycle.
    task automatic run_vec(input int sel, input int settle, input logic [3:0] e_cap,
                           input logic [3:0] e_mask, input logic [2:0] e_cnt,
                           input logic e_pass, input string tag);
        int last;
        logic [4:0] c;
        logic e_busy, e_done;
        logic [1:0] e_ab;
        last = 4 * (settle + 1) + 1;
        @(posedge clk); #1;
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
        for (int cy = 1; cy <= last; cy++) begin
            @(negedge clk);
            e_busy = (cy < last);
            e_done = (cy == last);
            e_ab   = e_busy ? 2'((cy - 1) / (settle + 1)) : 2'b00;
            c = ctl_of(sel);
            chk($sformatf("%s ab@%0d", tag, cy), {6'd0, c[4:3]}, {6'd0, e_ab});
            chk($sformatf("%s busy@%0d", tag, cy), {7'd0, c[2]}, {7'd0, e_busy});
            chk($sformatf("%s done@%0d", tag, cy), {7'd0, c[1]}, {7'd0, e_done});
            if (cy == last) check_results(sel, {tag, " at done"}, e_cap, e_mask, e_cnt, e_pass);
            @(posedge clk); #1;
        end
        // results must hold in IDLE
        repeat (2) @(posedge clk);
        @(negedge clk);
        c = ctl_of(sel);
        chk({tag, " idle busy/done"}, {6'd0, c[2:1]}, 8'd0);
        check_results(sel, {tag, " held"}, e_cap, e_mask, e_cnt, e_pass);
    endtask

    initial begin
        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        mode   = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ctl0", {3'd0, ctl_of(0)}, 8'd0);
        chk("reset res0", {5'd0, res_of(0)[10:8]}, 8'd0);
        chk("reset res0 lo", res_of(0)[7:0], 8'd0);
        chk("reset ctl1", {3'd0, ctl_of(1)}, 8'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        mode = 0;
        run_vec(0, 2, 4'b1110, 4'b0000, 3'd0, 1'b1, "or");
        mode = 1;
        run_vec(0, 2, 4'b1000, 4'b0110, 3'd2, 1'b0, "and");
        mode = 2;
        run_vec(0, 2, 4'b1111, 4'b0001, 3'd1, 1'b0, "stuck1");

        // start held 20 cycles: runs accepted at cycles 0 and 14
        mode = 0;
        @(posedge clk); #1;
        start0 = 1'b1;
        for (int cy = 1; cy <= 28; cy++) begin
            @(posedge clk); #1;
            if (cy == 20) start0 = 1'b0;
            @(negedge clk);
            chk($sformatf("hold busy@%0d", cy), {7'd0, busy0},
                {7'd0, ((cy >= 1 && cy <= 12) || (cy >= 15 && cy <= 26))});
            chk($sformatf("hold done@%0d", cy), {7'd0, done0},
                {7'd0, (cy == 13 || cy == 27)});
        end
        check_results(0, "hold end", 4'b1110, 4'b0000, 3'd0, 1'b1);

        // reset in cycle 6 of a run
        mode = 1;
        @(posedge clk); #1;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst ctl", {3'd0, ctl_of(0)}, 8'd0);
        chk("midrst cap/mask", res_of(0)[10:3], 8'd0);
        chk("midrst cnt", {5'd0, res_of(0)[2:0]}, 8'd0);
        @(negedge clk);
        chk("midrst stays idle", {3'd0, ctl_of(0)}, 8'd0);
        mode = 0;
        run_vec(0, 2, 4'b1110, 4'b0000, 3'd0, 1'b1, "after rst");

        // SETTLE = 0 instance
        run_vec(1, 0, 4'b1110, 4'b0000, 3'd0, 1'b1, "settle0 or");
        mode = 1;
        run_vec(1, 0, 4'b1000, 4'b0110, 3'd2, 1'b0, "settle0 and");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
